// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch stage feeding the instruction decoder. Holds the program counter,
// issues reads to a synchronous instruction ROM (data returns one cycle after
// the read strobe), and buffers returned instructions in a 2-entry queue that
// is presented to the decoder over a valid/ready handshake. Execute can
// redirect fetch with branch_valid/branch_target. Fetch stops for good once a
// HALT instruction is accepted downstream; only reset restarts it.
//
// Optional feature (compile-time macro IFU_STALL_COUNTER_EN):
//   adds a 16-bit saturating stall_count output counting cycles with
//   instr_valid && !instr_ready. Without the macro the port does not exist.
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   imem_en        out  ROM read strobe
//   imem_addr      out  ROM read address (0 when no read is issued)
//   imem_rdata     in   ROM data, valid the cycle after imem_en
//   instr_valid    out  queue head valid towards the decoder
//   instr_ready    in   decoder accepts when high with instr_valid
//   instruction    out  head-of-queue instruction (0 when empty)
//   instr_pc       out  address of the presented instruction (0 when empty)
//   branch_valid   in   redirect request from execute
//   branch_target  in   redirect address
//   halted         out  fetch stopped by HALT
//   stall_count    out  (IFU_STALL_COUNTER_EN only) saturating stall cycles
// ----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int                  PC_WIDTH    = 4,
    parameter int                  INSTR_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [3:0]          HALT_OPCODE = 4'b1111
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_en,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [PC_WIDTH-1:0]    instr_pc,
    input  logic                   branch_valid,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic                   halted
`ifdef IFU_STALL_COUNTER_EN
    ,
    output logic [15:0]            stall_count
`endif
);

    typedef enum logic {
        ST_FETCH  = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t                  state_reg;
    logic                    active_reg;      // reset-release synchroniser
    logic                    halted_reg;
    logic [PC_WIDTH-1:0]     fetch_pc_reg;
    logic                    inflight_reg;    // a read issued last cycle is returning now
    logic [PC_WIDTH-1:0]     inflight_pc_reg; // address of that returning read
    logic                    head_reg;
    logic                    tail_reg;
    logic [1:0]              count_reg;

    logic [1:0][INSTR_WIDTH-1:0] slot_instr;
    logic [1:0][PC_WIDTH-1:0]    slot_pc;

    logic                    fetching;
    logic                    q_valid;
    logic                    pop;
    logic                    head_is_halt;
    logic                    branch_take;
    logic                    halt_take;
    logic                    flush;
    logic                    push;
    logic                    issue;
    logic [2:0]              occupancy;
    logic [INSTR_WIDTH-1:0]  head_instr;
    logic [PC_WIDTH-1:0]     head_pc;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    // Nothing moves until the first edge after reset release; this keeps
    // the first read strobe one full cycle clear of the async deassertion.
    assign fetching     = active_reg && (state_reg == ST_FETCH);

    assign q_valid      = (count_reg != 2'd0);
    assign head_instr   = slot_instr[head_reg];
    assign head_pc      = slot_pc[head_reg];
    assign pop          = q_valid && instr_ready;
    assign head_is_halt = (head_instr[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);

    // A branch in the same cycle as a HALT pop squashes the HALT.
    assign branch_take  = fetching && branch_valid;
    assign halt_take    = fetching && pop && head_is_halt && !branch_valid;
    assign flush        = branch_take || halt_take;

    // Returning data is dropped whenever the queue is being flushed.
    assign push         = fetching && inflight_reg && !flush;

    // Slots that will be committed after this edge: queued plus returning,
    // less the entry leaving this cycle. Crediting the same-cycle pop is what
    // lets a continuously-ready decoder see one instruction per cycle, and
    // keeping the total below 2 before issuing means the queue never overflows.
    assign occupancy    = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};

    assign issue        = fetching && !branch_valid && !halt_take && (occupancy < 3'd2);

    assign imem_en      = issue;
    assign imem_addr    = issue ? fetch_pc_reg : '0;

    assign instr_valid  = q_valid;
    assign instruction  = q_valid ? head_instr : '0;
    assign instr_pc     = q_valid ? head_pc : '0;
    assign halted       = halted_reg;

    // ------------------------------------------------------------------
    // Queue storage: one register pair per slot, written at the tail.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            logic                   slot_wr;
            logic [INSTR_WIDTH-1:0] instr_reg;
            logic [PC_WIDTH-1:0]    pc_reg;

            assign slot_wr = push && (tail_reg == 1'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    instr_reg <= '0;
                    pc_reg    <= '0;
                end else if (slot_wr) begin
                    instr_reg <= imem_rdata;
                    pc_reg    <= inflight_pc_reg;
                end
            end

            assign slot_instr[gi] = instr_reg;
            assign slot_pc[gi]    = pc_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Fetch state machine, PC, in-flight tag and queue pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_FETCH;
            active_reg      <= 1'b0;
            halted_reg      <= 1'b0;
            fetch_pc_reg    <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
            head_reg        <= 1'b0;
            tail_reg        <= 1'b0;
            count_reg       <= 2'd0;
        end else begin
            active_reg <= 1'b1;

            if (fetching) begin
                inflight_reg <= issue;
                if (issue) begin
                    inflight_pc_reg <= fetch_pc_reg;
                end

                // Increment wraps naturally at 2^PC_WIDTH with no bubble.
                if (branch_take) begin
                    fetch_pc_reg <= branch_target;
                end else if (issue) begin
                    fetch_pc_reg <= fetch_pc_reg + {{(PC_WIDTH-1){1'b0}}, 1'b1};
                end

                if (flush) begin
                    head_reg  <= 1'b0;
                    tail_reg  <= 1'b0;
                    count_reg <= 2'd0;
                end else begin
                    if (push) begin
                        tail_reg <= ~tail_reg;
                    end
                    if (pop) begin
                        head_reg <= ~head_reg;
                    end
                    count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
                end

                if (halt_take) begin
                    state_reg  <= ST_HALTED;
                    halted_reg <= 1'b1;
                end
            end
        end
    end

`ifdef IFU_STALL_COUNTER_EN
    // ------------------------------------------------------------------
    // Back-pressure statistics: saturating, cleared only by reset.
    // ------------------------------------------------------------------
    logic [15:0] stall_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_reg <= '0;
        end else if (q_valid && !instr_ready && (stall_count_reg != 16'hFFFF)) begin
            stall_count_reg <= stall_count_reg + 16'd1;
        end
    end

    assign stall_count = stall_count_reg;
`endif

endmodule
